// File: rtl/xbar_ctrl_rr.sv
// PORT_N x PORT_N crossbar controller: per-input flit register, per-output round-robin arbiter.
// Define XBAR_STALL_CNT_EN to add per-output saturating stall counters on stall_cnt_o.
module xbar_ctrl_rr #(
    parameter int PORT_N = 5,
    parameter int SEL_W  = $clog2(PORT_N)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [PORT_N-1:0]         empty_i,
    output logic [PORT_N-1:0]         rd_en_o,
    output logic [PORT_N-1:0]         vld_input_o,
    input  logic [PORT_N*SEL_W-1:0]   dst_i,
    input  logic [PORT_N-1:0]         full_i,
    output logic [PORT_N-1:0]         wr_en_o,
    output logic [PORT_N*SEL_W-1:0]   out_sel_o,
    output logic [PORT_N-1:0]         drop_o
`ifdef XBAR_STALL_CNT_EN
    ,
    output logic [PORT_N*16-1:0]      stall_cnt_o
`endif
);

    localparam logic [SEL_W:0] PORT_LIM = (SEL_W+1)'(PORT_N);

    logic [PORT_N-1:0] vld_p1;
    logic [SEL_W-1:0]  ptr_p1 [PORT_N];

    logic [SEL_W-1:0]  dst [PORT_N];
    logic [PORT_N-1:0] req [PORT_N];
    logic [SEL_W-1:0]  sel [PORT_N];
    logic [PORT_N-1:0] wr_en;
    logic [PORT_N-1:0] gnt_in;
    logic [PORT_N-1:0] drop_in;

    // ---- stage p0: decode destinations, build request matrix req[o][i]
    always_comb begin
        for (int i = 0; i < PORT_N; i++) begin
            dst[i]     = dst_i[i*SEL_W +: SEL_W];
            drop_in[i] = vld_p1[i] & ({1'b0, dst[i]} >= PORT_LIM);
        end
    end

    always_comb begin
        for (int o = 0; o < PORT_N; o++) begin
            for (int i = 0; i < PORT_N; i++) begin
                req[o][i] = vld_p1[i] & (dst[i] == SEL_W'(o));
            end
        end
    end

    // ---- stage p0: circular search from ptr[o]; a full output grants nobody
    always_comb begin
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        logic             found;
        sum   = '0;
        idx   = '0;
        found = 1'b0;
        for (int o = 0; o < PORT_N; o++) begin
            wr_en[o] = 1'b0;
            sel[o]   = '0;
            found    = 1'b0;
            for (int k = 0; k < PORT_N; k++) begin
                sum = {1'b0, ptr_p1[o]} + (SEL_W+1)'(k);
                if (sum >= PORT_LIM) begin
                    sum = sum - PORT_LIM;
                end
                idx = sum[SEL_W-1:0];
                if (!full_i[o] && !found && req[o][idx]) begin
                    found    = 1'b1;
                    wr_en[o] = 1'b1;
                    sel[o]   = idx;
                end
            end
        end
    end

    // Each input requests a single output, so at most one output sets its bit.
    always_comb begin
        gnt_in = '0;
        for (int o = 0; o < PORT_N; o++) begin
            if (wr_en[o]) begin
                gnt_in[sel[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        out_sel_o = '0;
        for (int o = 0; o < PORT_N; o++) begin
            out_sel_o[o*SEL_W +: SEL_W] = sel[o];
        end
    end

    assign rd_en_o     = ~empty_i & (~vld_p1 | gnt_in | drop_in);
    assign wr_en_o     = wr_en;
    assign drop_o      = drop_in;
    assign vld_input_o = vld_p1;

    // ---- stage p1: input flit-valid registers and round-robin pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= '0;
            for (int o = 0; o < PORT_N; o++) begin
                ptr_p1[o] <= '0;
            end
        end else begin
            vld_p1 <= rd_en_o | (vld_p1 & ~gnt_in & ~drop_in);
            for (int o = 0; o < PORT_N; o++) begin
                if (wr_en[o]) begin
                    ptr_p1[o] <= (sel[o] == SEL_W'(PORT_N-1)) ? '0 : sel[o] + SEL_W'(1);
                end
            end
        end
    end

`ifdef XBAR_STALL_CNT_EN
    logic [15:0] stall_p1 [PORT_N];
    logic [15:0] losers   [PORT_N];

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // A full output stalls every requester; otherwise all but the winner lose.
    function automatic logic [15:0] count_losers(input logic [PORT_N-1:0] r, input logic blocked);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < PORT_N; i++) begin
            n = n + 16'(r[i]);
        end
        if (blocked) begin
            return n;
        end
        return (n != 16'd0) ? n - 16'd1 : 16'd0;
    endfunction

    always_comb begin
        for (int o = 0; o < PORT_N; o++) begin
            losers[o] = count_losers(req[o], full_i[o]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int o = 0; o < PORT_N; o++) begin
                stall_p1[o] <= '0;
            end
        end else begin
            for (int o = 0; o < PORT_N; o++) begin
                stall_p1[o] <= sat_add16(stall_p1[o], losers[o]);
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int o = 0; o < PORT_N; o++) begin
            stall_cnt_o[o*16 +: 16] = stall_p1[o];
        end
    end
`endif

endmodule

// File: tb/tb_xbar_ctrl_rr.sv
// Directed bench for xbar_ctrl_rr (PORT_N=5): expected outputs queued per step, checked mid-cycle.
module tb_xbar_ctrl_rr;

    logic        clk;
    logic        rst_n;
    logic [4:0]  empty;
    logic [4:0]  rd_en;
    logic [4:0]  vld;
    logic [14:0] dst_bus;
    logic [4:0]  full;
    logic [4:0]  wr_en;
    logic [14:0] out_sel;
    logic [4:0]  drop;
    logic [2:0]  d [5];

    typedef struct {
        string       tag;
        logic [4:0]  rd;
        logic [4:0]  vl;
        logic [4:0]  wr;
        logic [4:0]  dr;
        logic [14:0] sl;
    } exp_t;

    exp_t sb [$];
    int   n_assert;
    int   n_fail;

    xbar_ctrl_rr #(.PORT_N(5), .SEL_W(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .empty_i     (empty),
        .rd_en_o     (rd_en),
        .vld_input_o (vld),
        .dst_i       (dst_bus),
        .full_i      (full),
        .wr_en_o     (wr_en),
        .out_sel_o   (out_sel),
        .drop_o      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dst_bus = '0;
        for (int i = 0; i < 5; i++) begin
            dst_bus[i*3 +: 3] = d[i];
        end
    end

    function automatic logic [14:0] sl(input int a0, input int a1, input int a2, input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic expect_out(input string tag, input logic [4:0] rd, input logic [4:0] vl,
                              input logic [4:0] wr, input logic [4:0] dr, input logic [14:0] s);
        exp_t e;
        e.tag = tag; e.rd = rd; e.vl = vl; e.wr = wr; e.dr = dr; e.sl = s;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty got 0 entries want >=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (rd_en === e.rd) else begin
                n_fail++; $error("FAIL %s rd_en got %b want %b", e.tag, rd_en, e.rd);
            end
            n_assert++;
            assert (vld === e.vl) else begin
                n_fail++; $error("FAIL %s vld_input got %b want %b", e.tag, vld, e.vl);
            end
            n_assert++;
            assert (wr_en === e.wr) else begin
                n_fail++; $error("FAIL %s wr_en got %b want %b", e.tag, wr_en, e.wr);
            end
            n_assert++;
            assert (drop === e.dr) else begin
                n_fail++; $error("FAIL %s drop got %b want %b", e.tag, drop, e.dr);
            end
            n_assert++;
            assert (out_sel === e.sl) else begin
                n_fail++; $error("FAIL %s out_sel got %h want %h", e.tag, out_sel, e.sl);
            end
        end
    endtask

    // Inputs are set at a falling edge; outputs are checked 1 time unit later.
    task automatic step(input string tag, input logic [4:0] rd, input logic [4:0] vl,
                        input logic [4:0] wr, input logic [4:0] dr, input logic [14:0] s);
        expect_out(tag, rd, vl, wr, dr, s);
        #1;
        check_out();
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        empty    = 5'b11111;
        full     = 5'b00000;
        for (int i = 0; i < 5; i++) d[i] = 3'd0;
        @(negedge clk);

        step("rst_idle", 5'b00000, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        empty = 5'b11110;
        step("rst_rd", 5'b00001, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));

        // single flit 0 -> 3
        rst_n = 1'b1;
        d[0]  = 3'd3;
        step("t1_fill", 5'b00001, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        empty = 5'b11111;
        step("t1_xfer", 5'b00000, 5'b00001, 5'b01000, 5'b00000, sl(0,0,0,0,0));
        step("t1_idle", 5'b00000, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));

        // inputs 1,2,4 contend for output 2 with continuous refill
        d[1] = 3'd2; d[2] = 3'd2; d[4] = 3'd2;
        empty = 5'b01001;
        step("t2_fill", 5'b10110, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        for (int r = 0; r < 2; r++) begin
            step("t2_rr_i1", 5'b00010, 5'b10110, 5'b00100, 5'b00000, sl(0,0,1,0,0));
            step("t2_rr_i2", 5'b00100, 5'b10110, 5'b00100, 5'b00000, sl(0,0,2,0,0));
            step("t2_rr_i4", 5'b10000, 5'b10110, 5'b00100, 5'b00000, sl(0,0,4,0,0));
        end

        // permutation traffic, all five outputs busy
        d[0] = 3'd1; d[1] = 3'd2; d[2] = 3'd3; d[3] = 3'd4; d[4] = 3'd0;
        empty = 5'b00000;
        step("t3_mix", 5'b11111, 5'b10110, 5'b01101, 5'b00000, sl(4,0,1,2,0));
        step("t3_all", 5'b11111, 5'b11111, 5'b11111, 5'b00000, sl(4,0,1,2,3));

        // output 3 full for four cycles while input 0 waits on it
        empty = 5'b11110;
        full  = 5'b01000;
        d[0] = 3'd3; d[1] = 3'd1; d[2] = 3'd2; d[3] = 3'd4; d[4] = 3'd0;
        step("t4_full0", 5'b00000, 5'b11111, 5'b10111, 5'b00000, sl(4,1,2,0,3));
        for (int r = 0; r < 3; r++) begin
            step("t4_hold", 5'b00000, 5'b00001, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        end
        full = 5'b00000;
        step("t4_release", 5'b00001, 5'b00001, 5'b01000, 5'b00000, sl(0,0,0,0,0));
        empty = 5'b11111;
        step("t4_drain", 5'b00000, 5'b00001, 5'b01000, 5'b00000, sl(0,0,0,0,0));

        // out-of-range destination is dropped
        empty = 5'b11011;
        d[2]  = 3'd6;
        step("t5_fill", 5'b00100, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        step("t5_drop_refill", 5'b00100, 5'b00100, 5'b00000, 5'b00100, sl(0,0,0,0,0));
        empty = 5'b11111;
        step("t5_drop", 5'b00000, 5'b00100, 5'b00000, 5'b00100, sl(0,0,0,0,0));
        step("t5_clear", 5'b00000, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));

        // asynchronous reset mid-stream, then arbitration restarts at input 0
        d[0] = 3'd1; d[1] = 3'd2; d[2] = 3'd3; d[3] = 3'd4; d[4] = 3'd0;
        empty = 5'b00000;
        step("t6_fill", 5'b11111, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        expect_out("t6_all", 5'b11111, 5'b11111, 5'b11111, 5'b00000, sl(4,0,1,2,3));
        #1;
        check_out();
        #1;
        rst_n = 1'b0;
        expect_out("t6_rst_async", 5'b11111, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        #1;
        check_out();
        @(negedge clk);
        step("t6_rst_hold", 5'b11111, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) d[i] = 3'd2;
        step("t6_refill", 5'b11111, 5'b00000, 5'b00000, 5'b00000, sl(0,0,0,0,0));
        step("t6_rr_i0", 5'b00001, 5'b11111, 5'b00100, 5'b00000, sl(0,0,0,0,0));
        step("t6_rr_i1", 5'b00010, 5'b11111, 5'b00100, 5'b00000, sl(0,0,1,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
